lfsr_rand_arbiter: RTL and testbench
====================================

Name: lfsr_rand_arbiter

Overview:
- Shares one maximal-length Fibonacci LFSR among N_REQ requesters.
- Arbitrates with round-robin and hands each winner one pseudo-random word via a single-cycle grant/data strobe.
- After every draw, the LFSR is advanced ("stirred") STEPS times before the next grant, so consecutive consumers never see adjacent shift states.
- Used as the common random source for test-pattern, backoff and scrambler-seed consumers.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- WIDTH, 16, LFSR and data width.
- TAPS, 16'hB400, feedback mask; a set bit k means bit k feeds the XOR (x^16+x^14+x^13+x^11).
- SEED, 16'hACE1, reset value and substitute for an all-zero seed; must be nonzero.
- STEPS, 4, LFSR shifts between grants (1..15).

Ports:
- clk, in, 1, clock; all logic on rising edge.
- reset_n, in, 1, asynchronous active-low reset.
- seed_load, in, 1, load seed_data into the LFSR.
- seed_data, in, WIDTH, new seed; 0 is replaced by SEED.
- req, in, N_REQ, request per requester; level, held until granted.
- gnt, out, N_REQ, one-hot grant pulse, registered.
- rvalid, out, 1, high exactly when gnt != 0.
- rdata, out, WIDTH, random word for the granted requester; valid only with rvalid.
- busy, out, 1, high while in STIR.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - lfsr_ff = SEED, state = IDLE.
  - rr_ptr = N_REQ-1, so req[0] has top priority first.
  - gnt = 0, rvalid = 0, rdata = 0, busy = 0.
- LFSR step: lfsr_next = {lfsr_ff[WIDTH-2:0], ^(lfsr_ff & TAPS)}. The LFSR shifts only in STIR; it holds in IDLE.
- State IDLE:
  - If seed_load: load the seed and stay in IDLE; no grant.
  - Else if req != 0: pick the first set bit scanning rr_ptr+1, rr_ptr+2, … modulo N_REQ. On the next edge:
    - gnt = onehot(winner), rvalid = 1, rdata = current lfsr_ff.
    - rr_ptr = winner, cnt = STEPS, state = STIR.
  - Else: gnt = 0, rvalid = 0.
- State STIR:
  - gnt and rvalid are cleared after their one cycle; busy = 1.
  - Each cycle: lfsr_ff <= lfsr_next and cnt decrements.
  - When cnt reaches 1, that same edge advances the LFSR and returns to IDLE.
  - STIR therefore lasts exactly STEPS cycles.
  - Requests are ignored in STIR.
- Timing:
  - Decision at cycle T gives gnt at T+1.
  - The next decision is at T+STEPS+1, the next gnt at T+STEPS+2.
  - Back-to-back grant period = STEPS+1 cycles.
- seed_load priority: highest in every state.
  - Loads seed_data, or SEED if seed_data == 0.
  - Forces IDLE and clears cnt.
  - Suppresses any grant that would issue on that edge (gnt = 0).
  - rr_ptr is unchanged.
- Requests:
  - A requester may drop req before being granted; there is no penalty and no grant is issued to it.
  - Grant goes only to requesters whose req is high in the decision cycle.
- Zero lockup: the all-zero state is unreachable, because reset and seed substitution guarantee a nonzero value and the LFSR is maximal (period 2^WIDTH-1).
- Reset mid-STIR: outputs clear immediately and the LFSR returns to SEED.
- rdata holds its last value when rvalid = 0; consumers ignore it.

Test Plan:
- Reset, then req=0001 held: gnt=0001 and rdata=16'hACE1 one cycle after the first post-reset decision cycle; busy high for 4 cycles; next grant rdata=16'hCE1E, 5 cycles after the first.
- Stir sequence check with STEPS=1, req=0001 held: successive rdata = ACE1, 59C3, B387, 670F, CE1E.
- req=1111 held: grants in order 0001, 0010, 0100, 1000, 0001, each spaced exactly 5 cycles; rvalid matches gnt != 0 every cycle.
- Default parameters, req=1111 held, req[1] dropped after the first grant: order 0001, 0100, 1000, 0001; index 1 is never granted.
- seed_load=1 with seed_data=16'h1234 in the same cycle as an IDLE decision with req=0001: no gnt that edge; the next grant returns rdata=16'h1234. seed_load with seed_data=0: the next grant returns 16'hACE1.
- seed_load during STIR (cnt=2): state returns to IDLE immediately and busy drops. Asserting reset_n=0 mid-STIR clears gnt, rvalid and busy asynchronously; the first post-reset grant returns 16'hACE1.

Source files
------------

// File: rtl/lfsr_rand_arbiter_if.sv
// Request/grant/data bundle between random-word consumers and the shared LFSR arbiter.
// Consumers drive the master side; the arbiter drives the slave side.
interface lfsr_rand_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 16
);
   logic             seed_load;
   logic [WIDTH-1:0] seed_data;
   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] gnt;
   logic             rvalid;
   logic [WIDTH-1:0] rdata;
   logic             busy;

   modport master (
      output seed_load, seed_data, req,
      input  gnt, rvalid, rdata, busy
   );

   modport slave (
      input  seed_load, seed_data, req,
      output gnt, rvalid, rdata, busy
   );
endinterface

// File: rtl/lfsr_rand_arbiter.sv
// Round-robin arbiter that hands out words from one shared Fibonacci LFSR, stirring
// the register STEPS times after each draw so consecutive winners never see adjacent states.
module lfsr_rand_arbiter #(
   parameter int               N_REQ = 4,
   parameter int               WIDTH = 16,
   parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
   parameter logic [WIDTH-1:0] SEED  = 16'hACE1,
   parameter int               STEPS = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   lfsr_rand_arbiter_if.slave bus
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_STIR = 1'b1
   } state_t;

   // Feedback bit is the parity of the tapped positions.
   function automatic logic fb_parity(input logic [WIDTH-1:0] v);
      return ^(v & TAPS);
   endfunction

   function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] v);
      return {v[WIDTH-2:0], fb_parity(v)};
   endfunction

   state_t           state_q, state_d;
   logic [WIDTH-1:0] lfsr_q, lfsr_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic             rvalid_q, rvalid_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic             busy_q, busy_d;

   logic             found_s;
   logic [PTR_W-1:0] winner_s;
   logic [PTR_W-1:0] cand_s;
   logic             hit_s;

   // Round-robin scan starting just after the last winner; the first hit wins.
   always_comb begin
      found_s  = 1'b0;
      winner_s = rr_ptr_q;
      cand_s   = rr_ptr_q;
      hit_s    = 1'b0;
      for (int i = 1; i <= N_REQ; i++) begin
         cand_s   = PTR_W'((int'(rr_ptr_q) + i) % N_REQ);
         hit_s    = !found_s && bus.req[cand_s];
         winner_s = hit_s ? cand_s : winner_s;
         found_s  = found_s | hit_s;
      end
   end

   // Next-state, LFSR, pointer and output strobe computation.
   always_comb begin
      state_d  = state_q;
      lfsr_d   = lfsr_q;
      cnt_d    = cnt_q;
      rr_ptr_d = rr_ptr_q;
      gnt_d    = {N_REQ{1'b0}};
      rvalid_d = 1'b0;
      rdata_d  = rdata_q;
      busy_d   = 1'b0;

      if (bus.seed_load) begin
         // A zero seed would lock the LFSR, so it is swapped for the default.
         lfsr_d  = (bus.seed_data == {WIDTH{1'b0}}) ? SEED : bus.seed_data;
         state_d = ST_IDLE;
         cnt_d   = 4'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (found_s) begin
                  gnt_d    = {{(N_REQ-1){1'b0}}, 1'b1} << winner_s;
                  rvalid_d = 1'b1;
                  rdata_d  = lfsr_q;
                  rr_ptr_d = winner_s;
                  cnt_d    = 4'(STEPS);
                  state_d  = ST_STIR;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_STIR: begin
               lfsr_d = lfsr_step(lfsr_q);
               if (cnt_q <= 4'd1) begin
                  cnt_d   = 4'd0;
                  state_d = ST_IDLE;
               end else begin
                  cnt_d = cnt_q - 4'd1;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = 4'd0;
            end
         endcase
      end

      busy_d = (state_d == ST_STIR);
   end

   // State, LFSR and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         lfsr_q   <= SEED;
         cnt_q    <= 4'd0;
         rr_ptr_q <= PTR_W'(N_REQ - 1);
         gnt_q    <= {N_REQ{1'b0}};
         rvalid_q <= 1'b0;
         rdata_q  <= {WIDTH{1'b0}};
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         lfsr_q   <= lfsr_d;
         cnt_q    <= cnt_d;
         rr_ptr_q <= rr_ptr_d;
         gnt_q    <= gnt_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         busy_q   <= busy_d;
      end
   end

   assign bus.gnt    = gnt_q;
   assign bus.rvalid = rvalid_q;
   assign bus.rdata  = rdata_q;
   assign bus.busy   = busy_q;

endmodule

// File: tb/tb_lfsr_rand_arbiter.sv
// Directed bench for lfsr_rand_arbiter: a default instance (STEPS=4) plus a STEPS=1
// instance that exposes consecutive LFSR states.
module tb_lfsr_rand_arbiter;

   logic clk;
   logic reset_n;

   int check_cnt;
   int fail_cnt;

   lfsr_rand_arbiter_if #(.N_REQ(4), .WIDTH(16)) bus_d ();
   lfsr_rand_arbiter_if #(.N_REQ(4), .WIDTH(16)) bus_s1 ();

   lfsr_rand_arbiter #(.N_REQ(4), .WIDTH(16), .TAPS(16'hB400), .SEED(16'hACE1), .STEPS(4)) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus_d)
   );

   lfsr_rand_arbiter #(.N_REQ(4), .WIDTH(16), .TAPS(16'hB400), .SEED(16'hACE1), .STEPS(1)) u_dut_s1 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus_s1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      check_cnt++;
      if (obs !== exp) begin
         fail_cnt++;
         $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [15:0] s1_seq [5];
   logic [3:0]  exp_gnt;
   logic        exp_busy;

   initial begin
      check_cnt = 0;
      fail_cnt  = 0;
      s1_seq[0] = 16'hACE1;
      s1_seq[1] = 16'h59C3;
      s1_seq[2] = 16'hB387;
      s1_seq[3] = 16'h670F;
      s1_seq[4] = 16'hCE1E;

      reset_n          = 1'b0;
      bus_d.seed_load  = 1'b0;
      bus_d.seed_data  = 16'h0000;
      bus_d.req        = 4'b0000;
      bus_s1.seed_load = 1'b0;
      bus_s1.seed_data = 16'h0000;
      bus_s1.req       = 4'b0001;

      tick();
      tick();
      check("rst_gnt",    32'(bus_d.gnt),    32'h0);
      check("rst_rvalid", 32'(bus_d.rvalid), 32'h0);
      check("rst_rdata",  32'(bus_d.rdata),  32'h0);
      check("rst_busy",   32'(bus_d.busy),   32'h0);

      // Release reset with req[0] raised: this cycle is the first decision cycle.
      reset_n   = 1'b1;
      bus_d.req = 4'b0001;

      for (int k = 1; k <= 10; k++) begin
         tick();
         exp_gnt  = (k == 1 || k == 6) ? 4'b0001 : 4'b0000;
         exp_busy = (k >= 1 && k <= 4) || (k >= 6 && k <= 9);
         check($sformatf("a_gnt_%0d", k),    32'(bus_d.gnt),    32'(exp_gnt));
         check($sformatf("a_rvalid_%0d", k), 32'(bus_d.rvalid), 32'(exp_gnt != 4'b0000));
         check($sformatf("a_busy_%0d", k),   32'(bus_d.busy),   32'(exp_busy));
         if (k == 1 || k == 2) check($sformatf("a_rdata_%0d", k), 32'(bus_d.rdata), 32'h0000ACE1);
         if (k == 6) check("a_rdata_6", 32'(bus_d.rdata), 32'h0000CE1E);
         check($sformatf("s1_rvalid_%0d", k), 32'(bus_s1.rvalid), 32'(k % 2));
         if (k % 2 == 1) check($sformatf("s1_rdata_%0d", k), 32'(bus_s1.rdata), 32'(s1_seq[(k-1)/2]));
      end

      // All four requesting; last winner was index 0.
      bus_d.req = 4'b1111;
      for (int k = 11; k <= 30; k++) begin
         tick();
         case (k)
            11:      exp_gnt = 4'b0010;
            16:      exp_gnt = 4'b0100;
            21:      exp_gnt = 4'b1000;
            26:      exp_gnt = 4'b0001;
            default: exp_gnt = 4'b0000;
         endcase
         check($sformatf("b_gnt_%0d", k),    32'(bus_d.gnt),    32'(exp_gnt));
         check($sformatf("b_rvalid_%0d", k), 32'(bus_d.rvalid), 32'(exp_gnt != 4'b0000));
         if (k == 11) check("b_rdata_11", 32'(bus_d.rdata), 32'h0000E1E4);
      end

      // Requester 1 drops out; it must be skipped.
      bus_d.req = 4'b1101;
      for (int k = 31; k <= 45; k++) begin
         tick();
         case (k)
            31:      exp_gnt = 4'b0100;
            36:      exp_gnt = 4'b1000;
            41:      exp_gnt = 4'b0001;
            default: exp_gnt = 4'b0000;
         endcase
         check($sformatf("c_gnt_%0d", k), 32'(bus_d.gnt), 32'(exp_gnt));
      end

      // Seed load collides with an IDLE decision: no grant on that edge.
      bus_d.req       = 4'b0001;
      bus_d.seed_load = 1'b1;
      bus_d.seed_data = 16'h1234;
      tick();
      check("d_seed_gnt",    32'(bus_d.gnt),    32'h0);
      check("d_seed_rvalid", 32'(bus_d.rvalid), 32'h0);
      bus_d.seed_load = 1'b0;
      tick();
      check("d_gnt_after_seed",   32'(bus_d.gnt),   32'h1);
      check("d_rdata_after_seed", 32'(bus_d.rdata), 32'h00001234);
      check("d_busy_after_seed",  32'(bus_d.busy),  32'h1);
      tick();
      tick();
      check("d_busy_cnt2", 32'(bus_d.busy), 32'h1);

      // Zero seed loaded mid-STIR: back to IDLE at once, default seed substituted.
      bus_d.seed_load = 1'b1;
      bus_d.seed_data = 16'h0000;
      tick();
      check("d_stir_abort_busy", 32'(bus_d.busy), 32'h0);
      check("d_stir_abort_gnt",  32'(bus_d.gnt),  32'h0);
      bus_d.seed_load = 1'b0;
      tick();
      check("d_gnt_zero_seed",   32'(bus_d.gnt),   32'h1);
      check("d_rdata_zero_seed", 32'(bus_d.rdata), 32'h0000ACE1);

      // Asynchronous reset while the grant is showing and STIR is active.
      reset_n = 1'b0;
      #1;
      check("e_rst_gnt",    32'(bus_d.gnt),    32'h0);
      check("e_rst_rvalid", 32'(bus_d.rvalid), 32'h0);
      check("e_rst_busy",   32'(bus_d.busy),   32'h0);
      tick();
      reset_n = 1'b1;
      tick();
      check("e_gnt_post_rst",   32'(bus_d.gnt),   32'h1);
      check("e_rdata_post_rst", 32'(bus_d.rdata), 32'h0000ACE1);

      $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
      $finish;
   end

endmodule
